// File: rtl/uart_rx.sv
`default_nettype none
// ============================================================================
// Module      : uart_rx
// Description : 8N1 asynchronous serial receiver. Samples the line at mid-bit
//               using a fixed clocks-per-bit count and presents each correctly
//               framed byte with a one-cycle valid strobe. A low stop bit
//               produces a one-cycle frame_err strobe instead, and the
//               receiver then waits for the line to return high.
// Revision    : 1.0 - initial release
// ============================================================================
module uart_rx #(
  parameter int CLK_PER_BIT = 5208
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       rx,
  output logic [7:0] data_out,
  output logic       data_valid,
  output logic       frame_err,
  output logic       busy
);

  localparam int c_cnt_w = $clog2(CLK_PER_BIT);
  localparam int c_half  = CLK_PER_BIT / 2;

  localparam logic [c_cnt_w-1:0] c_half_m1 = c_cnt_w'(c_half - 1);
  localparam logic [c_cnt_w-1:0] c_last    = c_cnt_w'(CLK_PER_BIT - 1);
  localparam logic [c_cnt_w-1:0] c_cnt_one = c_cnt_w'(1);

  localparam logic [2:0] c_s_idle  = 3'd0;
  localparam logic [2:0] c_s_start = 3'd1;
  localparam logic [2:0] c_s_data  = 3'd2;
  localparam logic [2:0] c_s_stop  = 3'd3;
  localparam logic [2:0] c_s_break = 3'd4;

  logic               rx_meta_q;
  logic               rx_s_q;
  logic [2:0]         state_q,      state_d;
  logic [c_cnt_w-1:0] cnt_q,        cnt_d;
  logic [2:0]         bit_idx_q,    bit_idx_d;
  logic [7:0]         shift_q,      shift_d;
  logic [7:0]         data_out_q,   data_out_d;
  logic               data_valid_q, data_valid_d;
  logic               frame_err_q,  frame_err_d;

  // Two-flop synchronizer for the asynchronous serial line; idles high.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rx_meta_q <= 1'b1;
      rx_s_q    <= 1'b1;
    end else begin
      rx_meta_q <= rx;
      rx_s_q    <= rx_meta_q;
    end
  end

  // Frame FSM: start-bit validation at half a bit, then full-bit steps to
  // the centre of each data bit and of the stop bit.
  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    bit_idx_d    = bit_idx_q;
    shift_d      = shift_q;
    data_out_d   = data_out_q;
    data_valid_d = 1'b0;
    frame_err_d  = 1'b0;

    case (state_q)
      c_s_idle: begin
        if (!rx_s_q) begin
          state_d = c_s_start;
          cnt_d   = '0;
        end
      end

      c_s_start: begin
        if (cnt_q == c_half_m1) begin
          cnt_d     = '0;
          bit_idx_d = 3'd0;
          // A line already back high at mid-start-bit was only a glitch.
          state_d   = rx_s_q ? c_s_idle : c_s_data;
        end else begin
          cnt_d = cnt_q + c_cnt_one;
        end
      end

      c_s_data: begin
        if (cnt_q == c_last) begin
          cnt_d     = '0;
          shift_d   = {rx_s_q, shift_q[7:1]};
          bit_idx_d = bit_idx_q + 3'd1;
          if (bit_idx_q == 3'd7) begin
            state_d = c_s_stop;
          end
        end else begin
          cnt_d = cnt_q + c_cnt_one;
        end
      end

      c_s_stop: begin
        if (cnt_q == c_last) begin
          cnt_d = '0;
          if (rx_s_q) begin
            // Leaving at mid-stop-bit lets a directly following start bit
            // be caught.
            data_out_d   = shift_q;
            data_valid_d = 1'b1;
            state_d      = c_s_idle;
          end else begin
            frame_err_d = 1'b1;
            state_d     = c_s_break;
          end
        end else begin
          cnt_d = cnt_q + c_cnt_one;
        end
      end

      c_s_break: begin
        // Hold off until the line is released so a stuck-low line is not
        // decoded as a stream of zero bytes.
        if (rx_s_q) begin
          state_d = c_s_idle;
        end
      end

      default: begin
        state_d = c_s_idle;
        cnt_d   = '0;
      end
    endcase
  end

  // Frame state, counters and output registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= c_s_idle;
      cnt_q        <= '0;
      bit_idx_q    <= 3'd0;
      shift_q      <= 8'h00;
      data_out_q   <= 8'h00;
      data_valid_q <= 1'b0;
      frame_err_q  <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      bit_idx_q    <= bit_idx_d;
      shift_q      <= shift_d;
      data_out_q   <= data_out_d;
      data_valid_q <= data_valid_d;
      frame_err_q  <= frame_err_d;
    end
  end

  assign data_out   = data_out_q;
  assign data_valid = data_valid_q;
  assign frame_err  = frame_err_q;
  assign busy       = (state_q != c_s_idle);

endmodule
`default_nettype wire

// File: doc/uart_rx.md
# uart_rx

Asynchronous serial receiver; the downstream partner of the UART transmitter. It recovers 8N1 frames from the serial line and presents each byte on a parallel bus with a one-cycle valid strobe. The line is sampled at mid-bit using a free-running clock and a fixed clocks-per-bit count, the same as the transmitter's, so the two blocks loop back directly in simulation and on board.

## Interface
- CLK_PER_BIT, 5208: clk cycles per serial bit (50 MHz / 9600 baud); must be ≥ 4.
- clk  input  1  system clock; all logic on rising edge.
- rst  input  1  asynchronous, active-high reset.
- rx  input  1  serial line, idle high, asynchronous to clk.
- data_out  output  8  last correctly framed byte, LSB received first.
- data_valid  output  1  one-cycle strobe: data_out updated this cycle.
- frame_err  output  1  one-cycle strobe: stop bit sampled low.
- busy  output  1  high while a frame is in progress.

## Operation
- rx passes through a 2-flop synchronizer (both flops reset to 1); all decisions use the second flop, rx_s.
- Bit counter: width $clog2(CLK_PER_BIT). HALF = CLK_PER_BIT/2 (integer division). Bit index: 3 bits. Shift register: 8 bits.
- States:
  - IDLE: if rx_s==0, go to START with counter 0 and busy high.
  - START: increment the counter. At count==HALF-1, sample rx_s. If 0, go to DATA with counter 0 and bit index 0. If 1, treat it as a glitch: go to IDLE, drop busy, no strobe.
  - DATA: increment the counter. At count==CLK_PER_BIT-1, clear the counter and shift rx_s into the MSB of the shift register (right shift, so the first bit lands in bit 0 after 8 shifts). Then increment the bit index. After the 8th sample (index 7), go to STOP.
  - STOP: at count==CLK_PER_BIT-1, sample rx_s.
    - If 1: on the same edge, load data_out from the shift register, pulse data_valid, go to IDLE, drop busy.
    - If 0: pulse frame_err, leave data_out unchanged, go to BREAK.
  - BREAK: busy stays high. Wait for rx_s==1, then go to IDLE (busy low). This stops a held-low line from being decoded as 0x00 frames.
- Return to IDLE happens at mid-stop-bit, so a next start bit that directly follows the stop bit is caught.
- No overrun handling: data_out is overwritten by each new valid frame. The consumer must capture it on data_valid.
- Undefined state encodings go to IDLE.

## Timing
- Reset values: data_out=0x00, data_valid=0, frame_err=0, busy=0, state IDLE, synchronizer flops=1, counters=0.
- Reset mid-frame aborts immediately. No strobe is produced for the partial frame.
- rx falling edge to the IDLE→START transition: 2–3 clk cycles (synchronizer).
- Start-bit check: HALF cycles after entering START.
- Data bit n (0..7) is sampled (n+1)·CLK_PER_BIT cycles after the start check.
- Stop bit is sampled 9·CLK_PER_BIT cycles after the start check. data_valid/frame_err are high during the cycle after that edge, for exactly 1 cycle.
- Latency from the rx start-bit falling edge to data_valid ≈ 9.5·CLK_PER_BIT + 3 cycles.
- data_valid and frame_err are never high together.
- Glitches on rx shorter than about HALF−3 cycles never produce a strobe.
- Tolerance: the sample stays within the bit for a baud mismatch of up to ±4% at CLK_PER_BIT ≥ 16.

## Test plan
Use CLK_PER_BIT=16 in simulation unless noted.
- Loopback with uart_tx (same CLK_PER_BIT): transmit 0xA5 → exactly one data_valid pulse with data_out=0xA5, frame_err never high, busy low afterwards.
- Back-to-back frames 0x00, 0xFF, 0x3C, with the next start bit immediately after each stop bit → three data_valid pulses in order, correct values, no frame_err.
- Glitch rejection: rx low for 4 cycles, then high → busy pulses briefly then returns to 0; no data_valid or frame_err; data_out unchanged.
- Framing error: drive 0x55 with the stop bit low, then hold rx low for 40 cycles, then high → one frame_err pulse, no data_valid, data_out keeps its previous value, busy high until rx returns high, no further strobes.
- Reset mid-frame: assert rst during data bit 4 of 0x81 → all outputs return to reset values asynchronously. A following 0x81 frame after release → data_valid with 0x81.
- Baud skew: drive frames at CLK_PER_BIT ±3% (transmitter bit periods of 15.5 and 16.5 cycles using a fractional bench driver) with 0xC3 → received correctly both times.
